parallel_to_serial: RTL
=======================

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter: WIDTH, default 8, frame width in bits (legal: 2 to 32).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: load_data  input  WIDTH  parallel word to transmit.
REQ-006 Port: load_valid  input  1  load_data is valid.
REQ-007 Port: load_ready  output  1  block can accept a word this cycle.
REQ-008 Port: pause  input  1  downstream stall request.
REQ-009 Port: serial_out  output  1  current serial bit.
REQ-010 Port: serial_en  output  1  serial_out is valid this cycle; drives the receiver's enable.
REQ-011 Port: done  output  1  one-cycle pulse marking the last bit of a frame.
REQ-012 Port: busy  output  1  a frame is in the shifter.

Function
REQ-013 Handshake: a word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; no other condition accepts a word.
REQ-014 Storage: shift register plus one-entry holding buffer; load_ready SHALL equal NOT buffer_full, independent of load_valid.
REQ-015 FSM states: IDLE and SHIFT.
- IDLE -> SHIFT on accept.
- SHIFT -> IDLE after the last bit when the buffer is empty and no accept occurs.
- SHIFT -> SHIFT in all other cases.
REQ-016 Routing in IDLE: an accepted word SHALL load the shifter directly.
- Latency: first bit appears with serial_en=1 in the cycle after the accept edge.
REQ-017 Routing in SHIFT, buffer empty: an accepted word SHALL go into the buffer.
- Exception: on the edge that retires the last bit, the word loads the shifter directly.
REQ-018 At the edge that retires the last bit with the buffer full, the shifter SHALL load from the buffer and the buffer SHALL empty.
- Back-to-back frames therefore have no idle cycle between them.
REQ-019 In SHIFT with pause=0:
- serial_en=1.
- serial_out = current bit, ordered per MSB_FIRST.
- The bit counter advances once per cycle, from 0 to WIDTH-1.
REQ-020 In SHIFT with pause=1:
- serial_en=0 and done=0.
- serial_out, counter and shifter hold.
- Accepts into an empty buffer are still allowed.
REQ-021 done SHALL be 1 in exactly the cycle where serial_en=1 and the counter equals WIDTH-1.
REQ-022 In IDLE: serial_en=0, done=0, busy=0, serial_out=0.
REQ-023 busy SHALL be 1 in every SHIFT cycle, including paused cycles.
REQ-024 Counter width SHALL be ceil(log2(WIDTH)) bits; it SHALL reset to 0 on every shifter load, with no wrap past WIDTH-1.
REQ-025 pause asserted at the last bit SHALL delay done and the buffer transfer until the first unpaused cycle.

Reset
REQ-026 Reset asserted (reset=0) SHALL immediately force, without waiting for clk:
- state IDLE, counter 0, shifter 0, buffer empty;
- serial_out=0, serial_en=0, done=0, busy=0, load_ready=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard the buffered word; no partial done.
REQ-028 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-029 Shared package p2s_pkg SHALL hold the state encoding constants (IDLE, SHIFT) and the default WIDTH.
REQ-030 The holding buffer SHALL be a sub-module p2s_hold_buf: one-entry register with full flag, write, read-and-clear.
REQ-031 The FSM, counter and shifter SHALL reside in parallel_to_serial.

Verification
REQ-032 Single frame: load 8'hD5, MSB_FIRST=1 -> serial_out 1,1,0,1,0,1,0,1 on 8 consecutive serial_en cycles starting 1 cycle after accept; done with the 8th bit; busy=0 the next cycle.
REQ-033 Back-to-back: load 8'hD5 then 8'h3C (second accepted during the first frame) -> 16 consecutive serial_en cycles, done pulses at bits 8 and 16; load_ready=0 while the buffer is full.
REQ-034 Pause: load 8'hA5, pause=1 for 3 cycles after bit 4 -> serial_en=0 for those 3 cycles with serial_out held; total frame 11 cycles; bits still 10100101.
REQ-035 LSB-first: MSB_FIRST=0, load 8'h01 -> first bit 1, remaining 7 bits 0.
REQ-036 Reset mid-frame: reset=0 after bit 3 of 8'hFF with 8'h0F buffered -> all outputs 0 immediately, load_ready=1; after release there is no serial activity until a new load.
REQ-037 Loopback: drive serial_to_parallel (WIDTH=8) with serial_out/serial_en, load 8'hC3 -> receiver parallel_out=8'hC3 and receiver done after the 8th bit.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial transmitter.
package p2s_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    localparam int unsigned P2S_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/p2s_hold_buf.sv
// One-entry holding register with full flag; a read empties it.
module p2s_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_wr) begin
            r_full <= 1'b1;
            r_data <= i_wdata;
        end else if (i_rd) begin
            r_full <= 1'b0;
            r_data <= '0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial transmitter: shifter, bit counter and IDLE/SHIFT FSM,
// with a one-word holding buffer so back-to-back frames run gap-free.
module parallel_to_serial
    import p2s_pkg::*;
#(
    parameter int unsigned WIDTH     = P2S_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             pause,
    output logic             serial_out,
    output logic             serial_en,
    output logic             done,
    output logic             busy
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    p2s_state_t       r_state;
    p2s_state_t       w_next;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;

    logic             w_buf_full;
    logic [WIDTH-1:0] w_buf_data;
    logic             w_accept;
    logic             w_last;
    logic             w_buf_wr;
    logic             w_buf_rd;
    logic             w_load_direct;
    logic             w_load_buf;
    logic             w_shift_en;

    assign load_ready = ~w_buf_full;
    assign w_accept   = load_valid & ~w_buf_full;

    p2s_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_wr    (w_buf_wr),
        .i_wdata (load_data),
        .i_rd    (w_buf_rd),
        .o_full  (w_buf_full),
        .o_data  (w_buf_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_last        = 1'b0;
        w_buf_wr      = 1'b0;
        w_buf_rd      = 1'b0;
        w_load_direct = 1'b0;
        w_load_buf    = 1'b0;
        w_shift_en    = 1'b0;
        serial_en     = 1'b0;
        serial_out    = 1'b0;
        done          = 1'b0;
        busy          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load_direct = 1'b1;
                    w_next        = SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                serial_out = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
                if (!pause) begin
                    serial_en = 1'b1;
                    w_last    = (r_cnt == LAST_CNT);
                    done      = w_last;
                end
                // Retiring edge: refill from buffer, else take a new word, else stop
                if (w_last) begin
                    if (w_buf_full) begin
                        w_load_buf = 1'b1;
                        w_buf_rd   = 1'b1;
                    end else if (w_accept) begin
                        w_load_direct = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end else begin
                    w_shift_en = ~pause;
                    w_buf_wr   = w_accept;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load_direct) begin
            r_shift <= load_data;
            r_cnt   <= '0;
        end else if (w_load_buf) begin
            r_shift <= w_buf_data;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
            r_cnt   <= r_cnt + CW'(1);
        end
    end

endmodule
